// File: rtl/prio_enc8to3_filt.sv
// prio_enc8to3_filt: registered, glitch-filtered 8-to-3 priority encoder.
//
// The 8-bit line vector is double-flopped into the sys_clk domain. A new vector becomes the
// candidate and must then stay unchanged for FILTER_CYCLES consecutive cycles before it is
// committed to the outputs.
//
// Parameters:
//   FILTER_CYCLES  stable cycles required before commit (1..255)
//   PRIORITY_HIGH  1: highest set index wins, 0: lowest set index wins
//
// Ports:
//   sys_clk    system clock, rising edge
//   sys_rst_n  synchronous active-low reset
//   in         line vector, asynchronous to sys_clk
//   out1..3    committed code, out1 = LSB, out3 = MSB
//   valid      last committed vector was nonzero
//   code_stb   one-cycle pulse when {code, valid} changes at a commit
//   multi_err  sticky multi-hot flag (only with MULTI_HOT_ERR_EN defined)
//
// Optional feature macro: MULTI_HOT_ERR_EN adds the multi_err output and its logic.
module prio_enc8to3_filt #(
  parameter int unsigned FILTER_CYCLES = 4,
  parameter bit          PRIORITY_HIGH = 1'b1
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] in,
  output logic       out1,
  output logic       out2,
  output logic       out3,
  output logic       valid,
  output logic       code_stb
`ifdef MULTI_HOT_ERR_EN
  ,
  output logic       multi_err
`endif
);

  if ((FILTER_CYCLES == 0) || (FILTER_CYCLES > 255)) begin : gen_param_chk
    $error("prio_enc8to3_filt: FILTER_CYCLES must be in 1..255");
  end

  localparam logic [7:0] CntLast = 8'(FILTER_CYCLES - 1);

  localparam logic [0:0] StStable = 1'b0;
  localparam logic [0:0] StFilter = 1'b1;

  logic [7:0] sync1_q;
  logic [7:0] in_s_q;
  logic [7:0] cand_q, cand_d;
  logic [7:0] cnt_q, cnt_d;
  logic [0:0] state_q, state_d;
  logic [2:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       stb_q, stb_d;
  logic       commit;

  function automatic logic [2:0] encode(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    if (PRIORITY_HIGH) begin
      // Ascending scan: the last hit is the highest set index.
      for (int i = 0; i < 8; i++) begin
        if (v[i]) idx = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (v[i]) idx = 3'(i);
      end
    end
    return idx;
  endfunction

  always_comb begin
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    code_d  = code_q;
    valid_d = valid_q;
    stb_d   = 1'b0;
    commit  = 1'b0;

    case (state_q)
      StStable: begin
        if (in_s_q != cand_q) begin
          cand_d  = in_s_q;
          cnt_d   = 8'd0;
          state_d = StFilter;
        end
      end
      StFilter: begin
        if (in_s_q != cand_q) begin
          // Glitch: restart the stability window on the new vector.
          cand_d = in_s_q;
          cnt_d  = 8'd0;
        end else if (cnt_q == CntLast) begin
          commit  = 1'b1;
          state_d = StStable;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StStable;
    endcase

    if (commit) begin
      if (cand_q != 8'd0) begin
        code_d  = encode(cand_q);
        valid_d = 1'b1;
      end else begin
        // An all-zero vector keeps the last code and only drops valid.
        valid_d = 1'b0;
      end
      stb_d = ({code_d, valid_d} != {code_q, valid_q});
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      sync1_q <= 8'd0;
      in_s_q  <= 8'd0;
      cand_q  <= 8'd0;
      cnt_q   <= 8'd0;
      state_q <= StStable;
      code_q  <= 3'd0;
      valid_q <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      sync1_q <= in;
      in_s_q  <= sync1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      stb_q   <= stb_d;
    end
  end

  assign out1     = code_q[0];
  assign out2     = code_q[1];
  assign out3     = code_q[2];
  assign valid    = valid_q;
  assign code_stb = stb_q;

`ifdef MULTI_HOT_ERR_EN
  logic merr_q, merr_d;

  // More than one bit set: clearing the lowest set bit leaves something behind.
  always_comb begin
    merr_d = merr_q;
    if (commit && ((cand_q & (cand_q - 8'd1)) != 8'd0)) begin
      merr_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      merr_q <= 1'b0;
    end else begin
      merr_q <= merr_d;
    end
  end

  assign multi_err = merr_q;
`endif

endmodule

// File: tb/tb_prio_enc8to3_filt.sv
// Testbench for prio_enc8to3_filt (FILTER_CYCLES=4). Two instances share the stimulus:
// dut_hi (PRIORITY_HIGH=1) and dut_lo (PRIORITY_HIGH=0). Expected commits of dut_hi are
// queued with the edge they are due on; a monitor records every strobe of dut_hi.
module tb_prio_enc8to3_filt;

  typedef struct {
    int         due;
    logic [2:0] code;
    logic       valid;
  } exp_t;

  typedef struct {
    int         cyc;
    logic [2:0] code;
    logic       valid;
  } obs_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_v;
  logic       h_o1, h_o2, h_o3, h_valid, h_stb;
  logic       l_o1, l_o2, l_o3, l_valid, l_stb;
`ifdef MULTI_HOT_ERR_EN
  logic       h_merr, l_merr;
`endif

  int   cyc;
  int   n_vec;
  int   n_err;
  exp_t exp_q[$];
  obs_t obs_q[$];

  prio_enc8to3_filt #(
    .FILTER_CYCLES(4),
    .PRIORITY_HIGH(1'b1)
  ) dut_hi (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .in       (in_v),
    .out1     (h_o1),
    .out2     (h_o2),
    .out3     (h_o3),
    .valid    (h_valid),
    .code_stb (h_stb)
`ifdef MULTI_HOT_ERR_EN
    ,
    .multi_err(h_merr)
`endif
  );

  prio_enc8to3_filt #(
    .FILTER_CYCLES(4),
    .PRIORITY_HIGH(1'b0)
  ) dut_lo (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .in       (in_v),
    .out1     (l_o1),
    .out2     (l_o2),
    .out3     (l_o3),
    .valid    (l_valid),
    .code_stb (l_stb)
`ifdef MULTI_HOT_ERR_EN
    ,
    .multi_err(l_merr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: cyc is the number of edges seen when the strobe is visible.
  always @(negedge clk) begin
    if (h_stb === 1'b1) begin
      obs_q.push_back('{cyc: cyc, code: {h_o3, h_o2, h_o1}, valid: h_valid});
    end
  end

  // Advance n falling edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] v);
    in_v  = v;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    obs_q.delete();
  endtask

  task automatic test_reset;
    exp_t e;
    obs_t o;
    in_v  = 8'hFF;
    rst_n = 1'b0;
    tick(3);
    n_vec++;
    if ({h_o3, h_o2, h_o1, h_valid, h_stb} !== 5'b0 || {l_o3, l_o2, l_o1, l_valid, l_stb} !== 5'b0)
    begin
      n_err++;
      $display("FAIL reset_outputs: hi=%b lo=%b, required 00000 each",
               {h_o3, h_o2, h_o1, h_valid, h_stb}, {l_o3, l_o2, l_o1, l_valid, l_stb});
    end
`ifdef MULTI_HOT_ERR_EN
    n_vec++;
    if (h_merr !== 1'b0) begin
      n_err++;
      $display("FAIL reset_merr: got %b, required 0", h_merr);
    end
`endif
    obs_q.delete();
    rst_n = 1'b1;
    exp_q.push_back('{due: cyc + 7, code: 3'b111, valid: 1'b1});
    tick(14);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (obs_q.size() == 0) begin
        n_err++;
        $display("FAIL reset_commit: no strobe, required at edge %0d", e.due);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.due || o.code !== e.code || o.valid !== e.valid) begin
          n_err++;
          $display("FAIL reset_commit: edge %0d code %b valid %b, required edge %0d code %b valid %b",
                   o.cyc, o.code, o.valid, e.due, e.code, e.valid);
        end
      end
    end
    n_vec++;
    if (obs_q.size() != 0) begin
      n_err++;
      $display("FAIL reset_extra_stb: %0d extra strobes, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_single;
    exp_t e;
    obs_t o;
    do_reset(8'h00);
    in_v = 8'h04;
    exp_q.push_back('{due: cyc + 7, code: 3'b010, valid: 1'b1});
    tick(20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (obs_q.size() == 0) begin
        n_err++;
        $display("FAIL single_commit: no strobe, required at edge %0d", e.due);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.due || o.code !== e.code || o.valid !== e.valid) begin
          n_err++;
          $display("FAIL single_commit: edge %0d code %b valid %b, required edge %0d code %b valid %b",
                   o.cyc, o.code, o.valid, e.due, e.code, e.valid);
        end
      end
    end
    n_vec++;
    if (obs_q.size() != 0) begin
      n_err++;
      $display("FAIL single_extra_stb: %0d extra strobes, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  // Assumes 8'h04 is committed and stable.
  task automatic test_glitch;
    in_v = 8'h40;
    tick(3);
    in_v = 8'h04;
    tick(16);
    n_vec++;
    if ({h_o3, h_o2, h_o1} !== 3'b010 || h_valid !== 1'b1) begin
      n_err++;
      $display("FAIL glitch_hold: code %b valid %b, required code 010 valid 1",
               {h_o3, h_o2, h_o1}, h_valid);
    end
    n_vec++;
    if (obs_q.size() != 0) begin
      n_err++;
      $display("FAIL glitch_stb: %0d strobes, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  // Assumes 8'h04 is committed and stable.
  task automatic test_zero;
    exp_t e;
    obs_t o;
    in_v = 8'h00;
    exp_q.push_back('{due: cyc + 7, code: 3'b010, valid: 1'b0});
    tick(12);
    in_v = 8'h01;
    exp_q.push_back('{due: cyc + 7, code: 3'b000, valid: 1'b1});
    tick(12);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (obs_q.size() == 0) begin
        n_err++;
        $display("FAIL zero_commit: no strobe, required at edge %0d", e.due);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.due || o.code !== e.code || o.valid !== e.valid) begin
          n_err++;
          $display("FAIL zero_commit: edge %0d code %b valid %b, required edge %0d code %b valid %b",
                   o.cyc, o.code, o.valid, e.due, e.code, e.valid);
        end
      end
    end
    n_vec++;
    if (obs_q.size() != 0) begin
      n_err++;
      $display("FAIL zero_extra_stb: %0d extra strobes, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_priority;
    exp_t e;
    obs_t o;
    do_reset(8'h00);
    in_v = 8'b1001_0010;
    exp_q.push_back('{due: cyc + 7, code: 3'b111, valid: 1'b1});
    tick(12);
    n_vec++;
    if ({l_o3, l_o2, l_o1} !== 3'b001 || l_valid !== 1'b1) begin
      n_err++;
      $display("FAIL prio_low: code %b valid %b, required code 001 valid 1",
               {l_o3, l_o2, l_o1}, l_valid);
    end
`ifdef MULTI_HOT_ERR_EN
    n_vec++;
    if (h_merr !== 1'b1 || l_merr !== 1'b1) begin
      n_err++;
      $display("FAIL prio_merr_set: hi %b lo %b, required 1 1", h_merr, l_merr);
    end
`endif
    in_v = 8'h01;
    exp_q.push_back('{due: cyc + 7, code: 3'b000, valid: 1'b1});
    tick(12);
`ifdef MULTI_HOT_ERR_EN
    n_vec++;
    if (h_merr !== 1'b1) begin
      n_err++;
      $display("FAIL prio_merr_sticky: got %b, required 1", h_merr);
    end
`endif
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (obs_q.size() == 0) begin
        n_err++;
        $display("FAIL prio_high: no strobe, required at edge %0d", e.due);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.due || o.code !== e.code || o.valid !== e.valid) begin
          n_err++;
          $display("FAIL prio_high: edge %0d code %b valid %b, required edge %0d code %b valid %b",
                   o.cyc, o.code, o.valid, e.due, e.code, e.valid);
        end
      end
    end
    n_vec++;
    if (obs_q.size() != 0) begin
      n_err++;
      $display("FAIL prio_extra_stb: %0d extra strobes, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    obs_t o;
    do_reset(8'h00);
    in_v = 8'h80;
    tick(4);
    rst_n = 1'b0;      // reset sampled at the 5th edge after the change
    tick(1);
    rst_n = 1'b1;
    n_vec++;
    if ({h_o3, h_o2, h_o1, h_valid, h_stb} !== 5'b0) begin
      n_err++;
      $display("FAIL midreset_outputs: got %b, required 00000", {h_o3, h_o2, h_o1, h_valid, h_stb});
    end
    n_vec++;
    if (obs_q.size() != 0) begin
      n_err++;
      $display("FAIL midreset_early_stb: %0d strobes, required 0", obs_q.size());
      obs_q.delete();
    end
    exp_q.push_back('{due: cyc + 7, code: 3'b111, valid: 1'b1});
    tick(14);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (obs_q.size() == 0) begin
        n_err++;
        $display("FAIL midreset_commit: no strobe, required at edge %0d", e.due);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.due || o.code !== e.code || o.valid !== e.valid) begin
          n_err++;
          $display("FAIL midreset_commit: edge %0d code %b valid %b, required edge %0d code %b valid %b",
                   o.cyc, o.code, o.valid, e.due, e.code, e.valid);
        end
      end
    end
    n_vec++;
    if (obs_q.size() != 0) begin
      n_err++;
      $display("FAIL midreset_extra_stb: %0d extra strobes, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    in_v  = 8'h00;
    test_reset();
    test_single();
    test_glitch();
    test_zero();
    test_priority();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
